// File: rtl/key_schedule_seq.sv
// Sequential AES key schedule (AES-128/192/256 by KEY_BITS).
// Expands one 32-bit word per clock into an internal buffer after i_Start, then
// serves 128-bit round keys by round number with a one-cycle read latency.
// i_fDec mirrors the round index so the decrypt datapath can count upward.
module key_schedule_seq #(
    parameter int KEY_BITS = 128
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic                i_Start,
    input  logic [KEY_BITS-1:0] i_Key,
    output logic                o_Busy,
    output logic                o_Done,
    output logic                o_KeyValid,
    input  logic                i_RdEn,
    input  logic [3:0]          i_RdRound,
    input  logic                i_fDec,
    output logic [127:0]        o_RoundKey,
    output logic                o_RdValid,
    output logic                o_RdErr
);

    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    localparam logic [5:0] NK6   = 6'(NK);
    localparam logic [5:0] LAST6 = 6'(NW - 1);
    localparam logic [2:0] NKM1  = 3'(NK - 1);
    localparam logic [3:0] NR4   = 4'(NR);

    generate
        if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
            $error("key_schedule_seq: KEY_BITS must be 128, 192 or 256");
        end
    endgenerate

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_READY} state_t;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    state_t       state_q;
    logic         busy_q, done_q, kv_q;
    logic [7:0]   rcon_q;
    logic [5:0]   i_q;      // index of the word being produced
    logic [2:0]   m_q;      // i_q mod NK, kept as a wrap counter
    logic [31:0]  w_q [NW];
    logic [31:0]  w_new_d;
    logic         start_acc;
    logic         rd_ok_d;
    logic [5:0]   rd_base_d;
    logic         rd_valid_q, rd_err_q;
    logic [127:0] rk_q;

    assign start_acc  = i_Start && (state_q != S_EXPAND);
    assign o_Busy     = busy_q;
    assign o_Done     = done_q;
    assign o_KeyValid = kv_q;
    assign o_RdValid  = rd_valid_q;
    assign o_RdErr    = rd_err_q;
    assign o_RoundKey = rk_q;

    // Next schedule word from w[i-1] and w[i-NK].
    always_comb begin
        logic [31:0] prev, t;
        prev = w_q[i_q - 6'd1];
        t    = prev;
        if (m_q == 3'd0)
            t = sub_word({prev[23:0], prev[31:24]}) ^ {rcon_q, 24'h0};
        else if (NK == 8 && m_q == 3'd4)
            t = sub_word(prev);
        w_new_d = w_q[i_q - NK6] ^ t;
    end

    // Read request decode: effective round, range and schedule-valid check.
    always_comb begin
        logic [3:0] e;
        e         = i_fDec ? (NR4 - i_RdRound) : i_RdRound;
        rd_ok_d   = kv_q && (i_RdRound <= NR4);
        rd_base_d = rd_ok_d ? {e, 2'b00} : 6'd0;
    end

    // Control FSM: start handshake, word/rcon counters and status outputs.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            kv_q    <= 1'b0;
            rcon_q  <= 8'h01;
            i_q     <= 6'd0;
            m_q     <= 3'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_READY: begin
                    if (i_Start) begin
                        state_q <= S_EXPAND;
                        busy_q  <= 1'b1;
                        kv_q    <= 1'b0;
                        rcon_q  <= 8'h01;
                        i_q     <= NK6;
                        m_q     <= 3'd0;
                    end
                end
                S_EXPAND: begin
                    i_q <= i_q + 6'd1;
                    m_q <= (m_q == NKM1) ? 3'd0 : m_q + 3'd1;
                    if (m_q == 3'd0) rcon_q <= xtime(rcon_q);
                    if (i_q == LAST6) begin
                        state_q <= S_READY;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        kv_q    <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Word buffer: key load on start, one expanded word per cycle; never cleared.
    always_ff @(posedge i_Clk) begin
        if (start_acc) begin
            for (int k = 0; k < NK; k++)
                w_q[k] <= i_Key[KEY_BITS-1-32*k -: 32];
        end else if (state_q == S_EXPAND) begin
            w_q[i_q] <= w_new_d;
        end
    end

    // Registered read port; rejected reads leave the last round key in place.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rk_q       <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            if (i_RdEn) begin
                rd_valid_q <= rd_ok_d;
                rd_err_q   <= !rd_ok_d;
                if (rd_ok_d)
                    rk_q <= {w_q[rd_base_d], w_q[rd_base_d + 6'd1],
                             w_q[rd_base_d + 6'd2], w_q[rd_base_d + 6'd3]};
            end
        end
    end

endmodule
